// File: rtl/processor_pkg.sv
// Shared encodings for the six-instruction processor: opcodes, controller
// states and the datapath select codes.
package processor_pkg;

  typedef enum logic [3:0] {
    OP_LOAD      = 4'b0000,
    OP_STORE     = 4'b0001,
    OP_ADD       = 4'b0010,
    OP_LOADCONST = 4'b0011,
    OP_SUB       = 4'b0100,
    OP_JMPZ      = 4'b0101
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_ADD,
    S_SUB,
    S_LOADCONST,
    S_JMPZ,
    S_JMPZ_JUMP
  } state_t;

  typedef enum logic [1:0] {
    RF_S_ALU   = 2'b00,
    RF_S_DREG  = 2'b01,
    RF_S_WDATA = 2'b10
  } rf_s_t;

  typedef enum logic [1:0] {
    ALU_BYPASS = 2'b00,
    ALU_ADD    = 2'b01,
    ALU_SUB    = 2'b10
  } alu_s_t;

endpackage

// File: rtl/control_unit_if.sv
// Controller-side bus: instruction memory, data memory and datapath control.
interface control_unit_if
  import processor_pkg::*;
#(
  parameter int PCBITS  = 16,
  parameter int REGBITS = 4
) ();

  logic [15:0]        i_data;
  logic               rf_rp_zero;
  logic [PCBITS-1:0]  i_addr;
  logic               i_rd;
  logic [7:0]         d_addr;
  logic               d_rd;
  logic               d_wr;
  logic [7:0]         rf_w_data;
  logic [REGBITS-1:0] rf_w_addr;
  logic [REGBITS-1:0] rf_rp_addr;
  logic [REGBITS-1:0] rf_rq_addr;
  logic               rf_w_wr;
  logic               rf_rp_rd;
  logic               rf_rq_rd;
  rf_s_t              rf_s;
  alu_s_t             alu_s;

  modport master (
    input  i_data, rf_rp_zero,
    output i_addr, i_rd, d_addr, d_rd, d_wr, rf_w_data, rf_w_addr,
           rf_rp_addr, rf_rq_addr, rf_w_wr, rf_rp_rd, rf_rq_rd, rf_s, alu_s
  );

  modport slave (
    output i_data, rf_rp_zero,
    input  i_addr, i_rd, d_addr, d_rd, d_wr, rf_w_data, rf_w_addr,
           rf_rp_addr, rf_rq_addr, rf_w_wr, rf_rp_rd, rf_rq_rd, rf_s, alu_s
  );

endinterface

// File: rtl/program_counter.sv
// Program counter with clear, increment and relative-jump controls.
module program_counter #(
  parameter int PCBITS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              add_off,
  input  logic [PCBITS-1:0] off,
  output logic [PCBITS-1:0] pc
);

  // pc already points past the jmpz, so the -1 makes off relative to the jmpz itself
  always_ff @(posedge clk) begin
    if (!rst_n || clr)
      pc <= '0;
    else if (inc)
      pc <= pc + PCBITS'(1);
    else if (add_off)
      pc <= pc + off - PCBITS'(1);
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute controller for the six-instruction processor.
//   state       | meaning
//   S_INIT      | clear PC and IR
//   S_FETCH     | read instruction into IR, PC+1
//   S_DECODE    | branch on opcode
//   S_LOAD      | Ra <- D[d]
//   S_STORE     | D[d] <- Ra
//   S_ADD/S_SUB | Ra <- Rb +/- Rc
//   S_LOADCONST | Ra <- sext(c)
//   S_JMPZ      | read Ra, test zero flag
//   S_JMPZ_JUMP | PC <- PC + sext(off) - 1
module control_unit
  import processor_pkg::*;
#(
  parameter int PCBITS  = 16,
  parameter int REGBITS = 4
) (
  input logic            clk,
  input logic            rst_n,
  control_unit_if.master bus
);

  state_t             state, state_nxt;
  logic [15:0]        ir;
  logic [PCBITS-1:0]  pc;
  logic [3:0]         op;
  logic [REGBITS-1:0] ra, rb, rc;
  logic [7:0]         imm;
  logic               d_wr_raw, w_wr_raw;

  assign op  = ir[15:12];
  assign ra  = ir[11:8];
  assign rb  = ir[7:4];
  assign rc  = ir[3:0];
  assign imm = ir[7:0];

  program_counter #(.PCBITS(PCBITS)) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == S_INIT),
    .inc     (state == S_FETCH),
    .add_off (state == S_JMPZ_JUMP),
    .off     ({{(PCBITS-8){imm[7]}}, imm}),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT)
        ir <= '0;
      else if (state == S_FETCH)
        ir <= bus.i_data;
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.i_rd       = 1'b0;
    bus.d_addr     = '0;
    bus.d_rd       = 1'b0;
    d_wr_raw       = 1'b0;
    bus.rf_w_data  = '0;
    bus.rf_w_addr  = '0;
    bus.rf_rp_addr = '0;
    bus.rf_rq_addr = '0;
    w_wr_raw       = 1'b0;
    bus.rf_rp_rd   = 1'b0;
    bus.rf_rq_rd   = 1'b0;
    bus.rf_s       = RF_S_ALU;
    bus.alu_s      = ALU_BYPASS;
    case (state)
      S_INIT:  state_nxt = S_FETCH;
      S_FETCH: begin
        bus.i_rd  = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD:      state_nxt = S_LOAD;
          OP_STORE:     state_nxt = S_STORE;
          OP_ADD:       state_nxt = S_ADD;
          OP_LOADCONST: state_nxt = S_LOADCONST;
          OP_SUB:       state_nxt = S_SUB;
          OP_JMPZ:      state_nxt = S_JMPZ;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_LOAD: begin
        bus.d_addr    = imm;
        bus.d_rd      = 1'b1;
        bus.rf_s      = RF_S_DREG;
        bus.rf_w_addr = ra;
        w_wr_raw      = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_STORE: begin
        bus.d_addr     = imm;
        d_wr_raw       = 1'b1;
        bus.rf_rp_addr = ra;
        bus.rf_rp_rd   = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_ADD, S_SUB: begin
        bus.rf_rp_addr = rb;
        bus.rf_rq_addr = rc;
        bus.rf_rp_rd   = 1'b1;
        bus.rf_rq_rd   = 1'b1;
        bus.alu_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
        bus.rf_w_addr  = ra;
        w_wr_raw       = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_LOADCONST: begin
        bus.rf_w_data = imm;
        bus.rf_s      = RF_S_WDATA;
        bus.rf_w_addr = ra;
        w_wr_raw      = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_JMPZ: begin
        bus.rf_rp_addr = ra;
        bus.rf_rp_rd   = 1'b1;
        state_nxt      = bus.rf_rp_zero ? S_JMPZ_JUMP : S_FETCH;
      end
      S_JMPZ_JUMP: state_nxt = S_FETCH;
      default:     state_nxt = S_INIT;
    endcase
  end

  // Gating with rst_n keeps a reset edge from also committing a write
  assign bus.d_wr    = d_wr_raw & rst_n;
  assign bus.rf_w_wr = w_wr_raw & rst_n;
  assign bus.i_addr  = pc;

endmodule

// File: tb/tb_control_unit.sv
// Directed and random instruction streams checked against a per-instruction
// model of the controller's cycle-by-cycle outputs and program counter.
module tb_control_unit;

  typedef struct packed {
    logic       i_rd;
    logic [7:0] d_addr;
    logic       d_rd;
    logic       d_wr;
    logic [7:0] rf_w_data;
    logic [3:0] w_addr;
    logic [3:0] rp_addr;
    logic [3:0] rq_addr;
    logic       w_wr;
    logic       rp_rd;
    logic       rq_rd;
    logic [1:0] rf_s;
    logic [1:0] alu_s;
  } ctl_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] pc_m = 16'h0;

  control_unit_if #(.PCBITS(16), .REGBITS(4)) bus ();

  control_unit #(.PCBITS(16), .REGBITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic ctl_t observed();
    ctl_t o;
    o.i_rd      = bus.i_rd;
    o.d_addr    = bus.d_addr;
    o.d_rd      = bus.d_rd;
    o.d_wr      = bus.d_wr;
    o.rf_w_data = bus.rf_w_data;
    o.w_addr    = bus.rf_w_addr;
    o.rp_addr   = bus.rf_rp_addr;
    o.rq_addr   = bus.rf_rq_addr;
    o.w_wr      = bus.rf_w_wr;
    o.rp_rd     = bus.rf_rp_rd;
    o.rq_rd     = bus.rf_rq_rd;
    o.rf_s      = bus.rf_s;
    o.alu_s     = bus.alu_s;
    return o;
  endfunction

  // What the execute cycle of instruction w must drive, straight from the ISA table
  function automatic ctl_t exec_expect(input logic [15:0] w, input logic rst_low);
    ctl_t e = '0;
    case (w[15:12])
      4'd0: begin e.d_addr = w[7:0]; e.d_rd = 1; e.rf_s = 2'b01; e.w_addr = w[11:8]; e.w_wr = 1; end
      4'd1: begin e.d_addr = w[7:0]; e.d_wr = 1; e.rp_addr = w[11:8]; e.rp_rd = 1; end
      4'd2, 4'd4: begin
        e.rp_addr = w[7:4]; e.rq_addr = w[3:0]; e.rp_rd = 1; e.rq_rd = 1;
        e.alu_s = (w[15:12] == 4'd2) ? 2'b01 : 2'b10;
        e.w_addr = w[11:8]; e.w_wr = 1;
      end
      4'd3: begin e.rf_w_data = w[7:0]; e.rf_s = 2'b10; e.w_addr = w[11:8]; e.w_wr = 1; end
      4'd5: begin e.rp_addr = w[11:8]; e.rp_rd = 1; end
      default: e = '0;
    endcase
    if (rst_low) begin
      e.w_wr = 0;
      e.d_wr = 0;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input ctl_t exp, input logic [15:0] exp_addr);
    ctl_t o = observed();
    total++;
    assert (o === exp)
    else begin
      bad++;
      $error("FAIL %s ctl observed=%h expected=%h (pc_model=%h)", tag, o, exp, pc_m);
    end
    total++;
    assert (bus.i_addr === exp_addr)
    else begin
      bad++;
      $error("FAIL %s i_addr observed=%h expected=%h", tag, bus.i_addr, exp_addr);
    end
  endtask

  task automatic run_instr(input logic [15:0] w, input logic z, input logic rst_mid);
    ctl_t e;
    logic [15:0] pc_next;
    @(negedge clk);
    bus.i_data     = w;
    bus.rf_rp_zero = 1'($urandom_range(0, 1));
    #1;
    e = '0;
    e.i_rd = 1;
    chk("fetch", e, pc_m);
    pc_next = pc_m + 16'd1;
    @(negedge clk);
    bus.i_data = 16'($urandom);
    #1;
    chk("decode", '0, pc_next);
    if (w[15:12] <= 4'd5) begin
      @(negedge clk);
      bus.rf_rp_zero = z;
      if (rst_mid) rst_n = 1'b0;
      #1;
      chk("exec", exec_expect(w, rst_mid), pc_next);
    end
    if (rst_mid) begin
      @(negedge clk);
      #1;
      chk("init_after_reset", '0, 16'h0);
      rst_n = 1'b1;
      pc_m  = 16'h0;
    end else if (w[15:12] == 4'd5 && z) begin
      @(negedge clk);
      #1;
      chk("jmpz_jump", '0, pc_next);
      pc_m = pc_m + {{8{w[7]}}, w[7:0]};
    end else begin
      pc_m = pc_next;
    end
  endtask

  initial begin
    bus.i_data     = 16'h0;
    bus.rf_rp_zero = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset", '0, 16'h0);
    rst_n = 1'b1;
    pc_m  = 16'h0;

    run_instr(16'h3205, 1'b0, 1'b0);
    run_instr(16'h2312, 1'b0, 1'b0);
    run_instr(16'h4312, 1'b1, 1'b0);
    run_instr(16'h0410, 1'b0, 1'b0);
    run_instr(16'h1410, 1'b0, 1'b0);
    run_instr(16'h5AFD, 1'b1, 1'b0);
    run_instr(16'h5AFD, 1'b0, 1'b0);
    run_instr(16'hF000, 1'b1, 1'b0);
    run_instr(16'h50FB, 1'b1, 1'b0);
    run_instr(16'hF123, 1'b0, 1'b0);
    run_instr(16'h2312, 1'b0, 1'b1);
    run_instr(16'h1777, 1'b0, 1'b1);

    for (int i = 0; i < 80; i++) begin
      logic [15:0] w;
      logic        z;
      w = 16'($urandom);
      z = 1'($urandom_range(0, 1));
      run_instr(w, z, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
